idct_col_clip_buffer: RTL and testbench



---
 rtl/idct_col_clip_buffer.sv | 141 ++++++++++++++
 tb/tb_idct_col_clip_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_col_clip_buffer.sv
// idct_col_clip_buffer
//   Final stage of the column IDCT. Each accepted column of nine signed
//   32-bit terms goes through the last butterfly, the >>>14 descale, the
//   +128 level shift and the clip to 0..255. The eight resulting pixels are
//   written into one column of an 8x8 byte buffer. After eight columns the
//   block is streamed out in raster order, one byte per transfer.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort: back to FILL, counters cleared, buffer kept
//   col_in     nine signed terms, xk = col_in[32k+31:32k] (x5 unused)
//   in_valid   col_in valid
//   in_ready   block can accept a column (FILL state only)
//   out_data   unsigned pixel (zero outside DRAIN)
//   out_valid  out_data valid (DRAIN state)
//   out_ready  downstream accepts pixel
//   out_last   high with pixel 63 of the block
module idct_col_clip_buffer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [287:0] col_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  col_cnt_q, col_cnt_d;
  logic [5:0]  pix_cnt_q, pix_cnt_d;
  logic [7:0]  pix_buf_q [0:7][0:7];
  logic [7:0]  pix_buf_d [0:7][0:7];
  logic [7:0]  px [0:7];

  logic signed [31:0] x0, x1, x2, x3, x4, x6, x7, x8;
  logic               unused_x5;

  assign x0 = col_in[31:0];
  assign x1 = col_in[63:32];
  assign x2 = col_in[95:64];
  assign x3 = col_in[127:96];
  assign x4 = col_in[159:128];
  assign x6 = col_in[223:192];
  assign x7 = col_in[255:224];
  assign x8 = col_in[287:256];
  // x5 carries no information for this butterfly.
  assign unused_x5 = ^col_in[191:160];

  // Sign-extend both terms to 33 bits so the sum/difference never wraps.
  function automatic logic signed [32:0] bfly(input logic signed [31:0] a,
                                              input logic signed [31:0] b,
                                              input logic sub);
    logic signed [32:0] ae, be;
    ae = {a[31], a};
    be = {b[31], b};
    return sub ? (ae - be) : (ae + be);
  endfunction

  // Descale (floor, via arithmetic shift), level shift, clip to a byte.
  function automatic logic [7:0] descale_clip(input logic signed [32:0] s);
    logic signed [32:0] lv;
    lv = (s >>> 14) + 33'sd128;
    if (lv < 33'sd0)        return 8'd0;
    else if (lv > 33'sd255) return 8'd255;
    else                    return lv[7:0];
  endfunction

  always_comb begin
    px[0] = descale_clip(bfly(x7, x1, 1'b0));
    px[1] = descale_clip(bfly(x3, x2, 1'b0));
    px[2] = descale_clip(bfly(x0, x4, 1'b0));
    px[3] = descale_clip(bfly(x8, x6, 1'b0));
    px[4] = descale_clip(bfly(x8, x6, 1'b1));
    px[5] = descale_clip(bfly(x0, x4, 1'b1));
    px[6] = descale_clip(bfly(x3, x2, 1'b1));
    px[7] = descale_clip(bfly(x7, x1, 1'b1));
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    pix_cnt_d = pix_cnt_q;
    pix_buf_d = pix_buf_q;
    if (flush) begin
      // Abort wins over any handshake; old bytes are left to be overwritten.
      state_d   = FILL;
      col_cnt_d = 3'd0;
      pix_cnt_d = 6'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_valid) begin
            for (int r = 0; r < 8; r++) begin
              pix_buf_d[r][col_cnt_q] = px[r];
            end
            col_cnt_d = col_cnt_q + 3'd1;
            if (col_cnt_q == 3'd7) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            pix_cnt_d = pix_cnt_q + 6'd1;
            if (pix_cnt_q == 6'd63) state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      col_cnt_q <= 3'd0;
      pix_cnt_q <= 6'd0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          pix_buf_q[r][c] <= 8'd0;
        end
      end
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      pix_buf_q <= pix_buf_d;
    end
  end

  // in_ready is qualified by rst_n so it drops the instant reset asserts.
  assign in_ready  = rst_n && (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (pix_cnt_q == 6'd63);
  assign out_data  = (state_q == DRAIN) ? pix_buf_q[pix_cnt_q[5:3]][pix_cnt_q[2:0]] : 8'd0;

endmodule

// File: tb/tb_idct_col_clip_buffer.sv
module tb_idct_col_clip_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [287:0] col_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;

  int checks = 0;
  int failures = 0;

  // Reference model: plain 8x8 picture of expected bytes + column pointer.
  int model_buf [8][8];
  int model_col = 0;
  int ia [8] = '{7, 3, 0, 8, 8, 0, 3, 7};
  int ib [8] = '{1, 2, 4, 6, 6, 4, 2, 1};

  // Hand-computed table expectations, active while tbl_on.
  bit          tbl_on = 1'b0;
  int          tbl_col = 0;
  logic [63:0] tbl_exp = '0;

  typedef struct {
    logic [287:0] col;
    int           colidx;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [5];

  idct_col_clip_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .col_in(col_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int term(input logic [287:0] c, input int k);
    logic signed [31:0] t;
    t = c[32*k +: 32];
    return int'(t);
  endfunction

  // Real-number rule: floor((a +/- b) / 2^14) + 128, clipped to a byte.
  function automatic int mpix(input int a, input int b, input bit sub);
    longint s;
    s = sub ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
    s = s >>> 14;
    s = s + 128;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return int'(s);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) model_buf[r][c] = 0;
    model_col = 0;
  endtask

  function automatic logic [287:0] rand_col();
    logic [287:0] c;
    int v;
    for (int k = 0; k < 9; k++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom);
        1: v = int'($urandom_range(0, 8388607)) - 4194304;
        2: v = 0;
        default: v = 16384 * int'($urandom_range(0, 300)) - 16384 * 150
                     + int'($urandom_range(0, 32767)) - 16384;
      endcase
      c[32*k +: 32] = v;
    end
    return c;
  endfunction

  task automatic send_col(input logic [287:0] c);
    int n;
    n = 0;
    col_in = c;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int r = 0; r < 8; r++)
      model_buf[r][model_col] = mpix(term(c, ia[r]), term(c, ib[r]), r >= 4);
    model_col = (model_col + 1) % 8;
  endtask

  task automatic fill_block(input logic [287:0] cols [8]);
    for (int k = 0; k < 8; k++) begin
      send_col(cols[k]);
      if (k == 6) chk("no_valid_before_8th", int'(out_valid), 0);
      if (k == 7) chk("valid_after_8th", int'(out_valid), 1);
    end
  endtask

  // mode 0: out_ready always 1; mode 1: 0/1 alternating; mode 2: random stalls
  task automatic drain(input int npix, input int mode, input bit hold_valid,
                       output int cycles);
    int  n;
    bit  stall;
    int  exp;
    cycles = 0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      chk("drain_valid_timeout", 0, 1);
      return;
    end
    if (hold_valid) begin
      col_in = {9{32'h1234_5678}};
      in_valid = 1'b1;
    end
    for (int i = 0; i < npix; i++) begin
      exp = model_buf[i >> 3][i & 7];
      stall = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (stall) begin
        out_ready = 1'b0;
        chk("pix_before_stall", int'(out_data), exp);
        @(posedge clk); #1; cycles++;
        chk("pix_held", int'(out_data), exp);
        chk("last_held", int'(out_last), int'(i == 63));
        chk("valid_held", int'(out_valid), 1);
        if (hold_valid) chk("in_ready_low_stall", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      chk("pix", int'(out_data), exp);
      chk("last", int'(out_last), int'(i == 63));
      if (tbl_on && ((i & 7) == tbl_col))
        chk("tbl_pix", int'(out_data), int'(tbl_exp[8*(i >> 3) +: 8]));
      if (hold_valid) chk("in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1; cycles++;
      if (hold_valid && i == npix - 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    if (npix == 64) begin
      chk("in_ready_after_last", int'(in_ready), 1);
      chk("valid_after_last", int'(out_valid), 0);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    logic [287:0] cols [8];
    logic [287:0] c;
    int cyc;

    // Table of single-column vectors with hand-computed row pixels.
    // exp packs row r at bits [8r+7:8r].
    vecs[0].col = '0; vecs[0].colidx = 0;
    vecs[0].exp = {8{8'd128}};
    c = '0; c[32*7 +: 32] = 32'd16384;
    vecs[1].col = c; vecs[1].colidx = 2;
    vecs[1].exp = {8'd129, {6{8'd128}}, 8'd129};
    c = '0; c[32*7 +: 32] = 32'h7FFF_FFFF; c[32*1 +: 32] = 32'h7FFF_FFFF;
    c[32*0 +: 32] = -32'sd16777216; c[32*8 +: 32] = 32'hFFFF_FFFF;
    vecs[2].col = c; vecs[2].colidx = 0;
    vecs[2].exp = {8'd128, 8'd128, 8'd0, 8'd127, 8'd127, 8'd0, 8'd128, 8'd255};
    c = '0; c[32*0 +: 32] = 32'd1638400; c[32*4 +: 32] = 32'd163840;
    vecs[3].col = c; vecs[3].colidx = 5;
    vecs[3].exp = {8'd128, 8'd128, 8'd218, 8'd128, 8'd128, 8'd238, 8'd128, 8'd128};
    c = '0; c[32*3 +: 32] = 32'd819200; c[32*2 +: 32] = -32'sd327680;
    c[32*8 +: 32] = -32'sd1; c[32*6 +: 32] = -32'sd16384;
    vecs[4].col = c; vecs[4].colidx = 7;
    vecs[4].exp = {8'd128, 8'd198, 8'd128, 8'd128, 8'd126, 8'd128, 8'd158, 8'd128};

    model_clear();
    reset_pulse();

    // Table-driven vectors: full-rate drain, block period 8 + 64 cycles.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 8; k++) cols[k] = (k == vecs[v].colidx) ? vecs[v].col : '0;
      fill_block(cols);
      tbl_on = 1'b1; tbl_col = vecs[v].colidx; tbl_exp = vecs[v].exp;
      drain(64, 0, 1'b0, cyc);
      tbl_on = 1'b0;
      chk("drain_cycles_full", cyc, 64);
    end

    // Alternating backpressure with in_valid held high during DRAIN.
    for (int k = 0; k < 8; k++) cols[k] = rand_col();
    fill_block(cols);
    drain(64, 1, 1'b1, cyc);
    chk("drain_cycles_alt", cyc, 128);
    // Next block must start at column 0 again.
    for (int k = 0; k < 8; k++) cols[k] = rand_col();
    fill_block(cols);
    drain(64, 0, 1'b0, cyc);

    // Randomized blocks with random stalls.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) cols[k] = rand_col();
      fill_block(cols);
      drain(64, 2, 1'b0, cyc);
    end

    // Flush after 5 accepts, then 8 fresh columns.
    for (int k = 0; k < 5; k++) send_col(rand_col());
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_col = 0;
    chk("flush_fill_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 8; k++) cols[k] = rand_col();
    fill_block(cols);
    drain(64, 2, 1'b0, cyc);

    // Flush during DRAIN at pixel 20 (with out_ready high the same cycle).
    for (int k = 0; k < 8; k++) cols[k] = rand_col();
    fill_block(cols);
    drain(20, 0, 1'b0, cyc);
    chk("pix20_before_flush", int'(out_data), model_buf[2][4]);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_drain_valid", int'(out_valid), 0);
    chk("flush_drain_in_ready", int'(in_ready), 1);
    model_col = 0;
    for (int k = 0; k < 8; k++) cols[k] = rand_col();
    fill_block(cols);
    drain(64, 0, 1'b0, cyc);

    // Asynchronous reset mid-DRAIN at pixel 30.
    for (int k = 0; k < 8; k++) cols[k] = rand_col();
    fill_block(cols);
    drain(30, 0, 1'b0, cyc);
    reset_pulse();
    for (int k = 0; k < 8; k++) cols[k] = '0;
    fill_block(cols);
    drain(64, 0, 1'b0, cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
